fixed_divide_q8_8_seq: RTL and testbench
========================================

Name: fixed_divide_q8_8_seq

Overview:
- Sequential signed fixed-point divider for the noise-cancelling datapath. It is the inverse of the Q8.8 multiply stage: out1 = (in1 / in2) with in1, in2 and out1 all signed Q8.8.
- Iterative restoring division, one quotient bit per clock, with a start/busy/done handshake.
- Used for normalisation and gain correction where the multiplier cannot be reused.

Parameters:
- WIDTH, 16, total operand/result width (two's complement).
- FRAC, 8, fractional bits of operands and result.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- in1  input  WIDTH  dividend, signed Q8.8.
- in2  input  WIDTH  divisor, signed Q8.8.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when out1/flags are valid.
- out1  output  WIDTH  quotient, signed Q8.8, held until the next done.
- ovf  output  1  result saturated; valid with done, held.
- dz  output  1  divisor was zero; valid with done, held.

Behaviour:
- Reset: rst=0 at any rising edge forces state IDLE and busy=0, done=0, out1=0, ovf=0, dz=0. Internal registers are cleared. Reset mid-operation aborts the division and produces no done pulse.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 at edge E0 latches in1/in2, sign = in1[MSB]^in2[MSB], and magnitudes |in1|, |in2| (WIDTH+1 bits, so -32768 is exact).
  - Loads dividend = |in1| << FRAC (WIDTH+FRAC bits), remainder = 0, counter = 0.
  - Moves to CALC; busy=1 after E0.
- CALC: at edges E1..E(WIDTH+FRAC), i.e. 24 iterations by default:
  - Shift remainder left, bringing in the dividend MSB.
  - If remainder >= |in2|, subtract and set the quotient bit to 1; otherwise set it to 0.
  - After the last iteration, go to FIN.
- FIN (edge E25 by default):
  - Apply sign to the magnitude quotient (truncation toward zero).
  - Positive result with magnitude > 2^(WIDTH-1)-1: out1=0x7FFF, ovf=1.
  - Negative result with magnitude > 2^(WIDTH-1): out1=0x8000, ovf=1.
  - Otherwise out1 = signed quotient, ovf=0.
  - dz=1 when the latched in2 == 0. In that case out1 = 0x7FFF if in1 >= 0, else 0x8000, and ovf=0.
  - The dz case still takes the full fixed latency.
  - done=1 for exactly one cycle after E25; busy=0; return to IDLE.
- Latency: fixed at WIDTH+FRAC+1 edges from the start edge to the edge that raises done (25 by default). Throughput is one division per WIDTH+FRAC+2 cycles.
- Handshake:
  - start while busy=1 is ignored.
  - in1/in2 may change freely after E0.
  - start asserted in the same cycle done is high is accepted, giving back-to-back operation.
- Zero result: a zero result is always 0x0000, including when sign=1.
- Outputs: all outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> out1=0, busy=0, done=0, ovf=0, dz=0.
- Basic divisions, each checked for done exactly 25 edges after the start edge, one cycle wide:
  - in1=0x0300, in2=0x0200 -> out1=0x0180.
  - in1=0xFE80, in2=0x0080 -> out1=0xFD00.
- Truncation toward zero:
  - in1=0x0100, in2=0x0300 -> out1=0x0055.
  - in1=0xFF00, in2=0x0300 -> out1=0xFFAB.
- Saturation and divide by zero:
  - in1=0x7F00, in2=0x0010 -> out1=0x7FFF, ovf=1.
  - in1=0x8000, in2=0x0080 -> out1=0x8000, ovf=1.
  - in1=0xFF00, in2=0x0000 -> out1=0x8000, dz=1, ovf=0.
- Handshake:
  - Pulse start again at edge 10 with different operands -> ignored; the first result is unaffected.
  - start held high through done -> second result done exactly 26 cycles after the first.
- Reset mid-operation: rst=0 at edge 12 -> busy=0 and out1=0 on the next cycle; no done pulse. A subsequent start with 0x0000/0xFF00 -> out1=0x0000.

Source files
------------

// File: rtl/fixed_divide_q8_8_seq.sv
// Sequential signed Q8.8 divider: restoring division on magnitudes, one quotient
// bit per clock, followed by sign application and saturation to the Q8.8 range.
module fixed_divide_q8_8_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] in1,
  input  logic signed [WIDTH-1:0] in2,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] out1,
  output logic                    ovf,
  output logic                    dz
);

  localparam int QW = WIDTH + FRAC;   // quotient / shifted-dividend width
  localparam int MW = WIDTH + 1;      // magnitude width, holds |-2^(WIDTH-1)| exactly
  localparam int RW = WIDTH + 2;      // partial remainder plus one shift bit
  localparam int CW = $clog2(QW + 1);

  localparam logic [QW-1:0]    POS_LIM = QW'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic [QW-1:0]    NEG_LIM = QW'(64'd1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [QW-1:0]    dvd_q, dvd_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [QW-1:0]    quot_q, quot_d;
  logic [MW-1:0]    dvs_q, dvs_d;
  logic             sign_q, sign_d;
  logic             neg1_q, neg1_d;
  logic             zdiv_q, zdiv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [RW-1:0]    rem_sh;
  logic [MW-1:0]    mag1;
  logic [WIDTH:0]   sat_res;

  function automatic logic [MW-1:0] abs_mag(input logic signed [WIDTH-1:0] x);
    logic signed [MW-1:0] ext;
    ext = {x[WIDTH-1], x};
    return ext[MW-1] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  // Returns {ovf, value}; a zero magnitude yields zero regardless of sign.
  function automatic logic [WIDTH:0] saturate(input logic neg, input logic [QW-1:0] mag);
    logic [QW-1:0] neg_mag;
    neg_mag = -mag;
    if (!neg) begin
      if (mag > POS_LIM) return {1'b1, SAT_MAX};
      return {1'b0, mag[WIDTH-1:0]};
    end
    if (mag > NEG_LIM) return {1'b1, SAT_MIN};
    return {1'b0, neg_mag[WIDTH-1:0]};
  endfunction

  assign mag1    = abs_mag(in1);
  assign rem_sh  = {rem_q[RW-2:0], dvd_q[QW-1]};
  assign sat_res = saturate(sign_q, quot_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    sign_d  = sign_q;
    neg1_d  = neg1_q;
    zdiv_d  = zdiv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out1_d  = out1_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = QW'({mag1, {FRAC{1'b0}}});
          dvs_d   = abs_mag(in2);
          sign_d  = in1[WIDTH-1] ^ in2[WIDTH-1];
          neg1_d  = in1[WIDTH-1];
          zdiv_d  = (in2 == '0);
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (rem_sh >= RW'(dvs_q)) begin
          rem_d  = rem_sh - RW'(dvs_q);
          quot_d = {quot_q[QW-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          quot_d = {quot_q[QW-2:0], 1'b0};
        end
        dvd_d = {dvd_q[QW-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) state_d = FIN;
      end
      FIN: begin
        if (zdiv_q) begin
          out1_d = neg1_q ? SAT_MIN : SAT_MAX;
          ovf_d  = 1'b0;
          dz_d   = 1'b1;
        end else begin
          out1_d = sat_res[WIDTH-1:0];
          ovf_d  = sat_res[WIDTH];
          dz_d   = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      neg1_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out1_q  <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      neg1_q  <= neg1_d;
      zdiv_q  <= zdiv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out1_q  <= out1_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out1 = out1_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_fixed_divide_q8_8_seq.sv
// Scoreboard bench for fixed_divide_q8_8_seq: directed cases plus random operands
// checked against an arithmetic reference model, with exact done timing.
module tb_fixed_divide_q8_8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in1, in2;
  logic        busy, done, ovf, dz;
  logic [15:0] out1;

  fixed_divide_q8_8_seq #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out1(out1), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] out;
    logic        ovf;
    logic        dz;
    int          edge_n;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: real-valued quotient scaled by 2^8, truncated toward zero, clamped.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return {(sa >= 0) ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    q = (sa * 256) / sb;
    if (q > 32767)  return {16'h7FFF, 1'b1, 1'b0};
    if (q < -32768) return {16'h8000, 1'b1, 1'b0};
    return {q[15:0], 1'b0, 1'b0};
  endfunction

  function automatic exp_t mk(input logic [17:0] r, input int e);
    exp_t x;
    x.out = r[17:2]; x.ovf = r[1]; x.dz = r[0]; x.edge_n = e;
    return x;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected no done (cyc=%0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result{out1,ovf,dz}", {14'd0, out1, ovf, dz}, {14'd0, e.out, e.ovf, e.dz});
        check("done_edge", cyc, e.edge_n);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [17:0] r);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    sbq.push_back(mk(r, cyc + 26));
    @(negedge clk);
    start = 1'b0;
    in1 = 16'($urandom); in2 = 16'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++; fails++;
      $display("FAIL timeout: got %0d pending results expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [15:0] a, b;
    rst = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    check("rst_out1", {16'd0, out1}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_dz",   {31'd0, dz},   32'd0);
    rst = 1'b1;

    issue(16'h0300, 16'h0200, {16'h0180, 2'b00}); wait_drain();
    issue(16'hFE80, 16'h0080, {16'hFD00, 2'b00}); wait_drain();
    issue(16'h0100, 16'h0300, {16'h0055, 2'b00}); wait_drain();
    issue(16'hFF00, 16'h0300, {16'hFFAB, 2'b00}); wait_drain();
    issue(16'h7F00, 16'h0010, {16'h7FFF, 2'b10}); wait_drain();
    issue(16'h8000, 16'h0080, {16'h8000, 2'b10}); wait_drain();
    issue(16'hFF00, 16'h0000, {16'h8000, 2'b01}); wait_drain();
    issue(16'h0100, 16'h0000, {16'h7FFF, 2'b01}); wait_drain();
    issue(16'h8000, 16'hFF00, {16'h7FFF, 2'b10}); wait_drain();
    issue(16'h8000, 16'h0100, {16'h8000, 2'b00}); wait_drain();

    // Start pulsed at edge 10 of a running division must be ignored.
    issue(16'h0300, 16'h0200, {16'h0180, 2'b00});
    repeat (8) @(negedge clk);
    in1 = 16'h7000; in2 = 16'h0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);

    // start held through done: second result exactly 26 cycles after the first.
    @(negedge clk);
    in1 = 16'h0300; in2 = 16'h0200; start = 1'b1;
    sbq.push_back(mk({16'h0180, 2'b00}, cyc + 26));
    sbq.push_back(mk({16'hFFAB, 2'b00}, cyc + 52));
    @(negedge clk);
    in1 = 16'hFF00; in2 = 16'h0300;
    repeat (26) @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset at edge 12 aborts the division without a done pulse.
    issue(16'h1234, 16'h0100, model(16'h1234, 16'h0100));
    repeat (10) @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out1", {16'd0, out1}, 32'd0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    issue(16'h0000, 16'hFF00, {16'h0000, 2'b00}); wait_drain();

    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'h0000;
        1:       b = 16'($signed(8'($urandom)));
        default: b = 16'($urandom);
      endcase
      if (i % 3 == 0) a = 16'($signed(12'($urandom)));
      issue(a, b, model(a, b));
      wait_drain();
    end

    repeat (30) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
